// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - Q8.8 activation types and constants shared with siluPWL
package act_pkg;

   localparam int Q_FRAC    = 8;
   localparam int ACC_W_DEF = 32;

   // 16-bit Q8.8 two's-complement activation word
   typedef logic signed [2*Q_FRAC-1:0] act_t;

   localparam act_t Q_MAX = 16'sh7FFF;
   localparam act_t Q_MIN = 16'sh8000;

endpackage

// File: rtl/requant_round_sat.sv
// rtl/requant_round_sat.sv - round-half-up arithmetic right shift with Q8.8 saturation, registered
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_en          pipeline advance enable
//   i_valid       product valid
//   i_prod        signed product, PROD_W bits
//   i_last        tile-last flag travelling with the product
//   i_shift       right-shift amount, 0..47
//   o_valid       registered valid
//   o_data        saturated Q8.8 result
//   o_last        registered last flag
module requant_round_sat
   import act_pkg::*;
#(
   parameter int PROD_W = 50
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_valid,
   input  logic signed [PROD_W-1:0] i_prod,
   input  logic                     i_last,
   input  logic [5:0]               i_shift,
   output logic                     o_valid,
   output act_t                     o_data,
   output logic                     o_last
);

   // One guard bit so adding the rounding constant can never overflow
   logic signed [PROD_W:0] w_ext;
   logic signed [PROD_W:0] w_rnd;
   logic signed [PROD_W:0] w_sum;
   logic signed [PROD_W:0] w_shr;
   logic [PROD_W-15:0]     w_hi;
   logic                   w_in_range;
   act_t                   w_sat;

   assign w_ext = {i_prod[PROD_W-1], i_prod};
   assign w_rnd = (i_shift == 6'd0) ? '0 : ((PROD_W+1)'(1) << (i_shift - 6'd1));
   assign w_sum = w_ext + w_rnd;
   assign w_shr = w_sum >>> i_shift;

   // Fits in 16 bits only when everything from bit 15 up is a copy of the sign
   assign w_hi       = w_shr[PROD_W:15];
   assign w_in_range = (&w_hi) | ~(|w_hi);
   assign w_sat      = w_in_range ? act_t'(w_shr[15:0]) : (w_shr[PROD_W] ? Q_MIN : Q_MAX);

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
      end else if (i_en) begin
         o_valid <= i_valid;
         o_data  <= w_sat;
         o_last  <= i_last;
      end
   end

endmodule

// File: rtl/acc_requant_stage.sv
// rtl/acc_requant_stage.sv - accumulator to Q8.8 requantiser, 3-stage valid/ready pipeline
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_bias/cfg_scale  per-channel table write
//   cfg_shift, cfg_nch               static shift amount and active channel count
//   in_valid/in_ready/in_acc/in_last accumulator stream
//   out_valid/out_ready/out_data/out_last  activation stream
//   busy                             any stage holds valid data
module acc_requant_stage
   import act_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int SCALE_W = 16,
   parameter int NCH_MAX = 16,
   parameter int CH_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_addr,
   input  logic signed [ACC_W-1:0] cfg_bias,
   input  logic [SCALE_W-1:0]      cfg_scale,
   input  logic [5:0]              cfg_shift,
   input  logic [CH_W:0]           cfg_nch,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [ACC_W-1:0] in_acc,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output act_t                    out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int SUM_W  = ACC_W + 1;
   localparam int PROD_W = ACC_W + SCALE_W + 2;

   logic signed [ACC_W-1:0]  r_bias  [NCH_MAX];
   logic [SCALE_W-1:0]       r_scale [NCH_MAX];
   logic [CH_W-1:0]          r_ch;

   logic                     r_s1_valid;
   logic signed [SUM_W-1:0]  r_s1_sum;
   logic [SCALE_W-1:0]       r_s1_scale;
   logic                     r_s1_last;

   logic                     r_s2_valid;
   logic signed [PROD_W-1:0] r_s2_prod;
   logic                     r_s2_last;

   logic                     w_en;
   logic                     w_xfer_in;
   logic                     w_ch_wrap;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [PROD_W-1:0] w_prod;

   // Whole pipe moves in lockstep; only a stalled output holds it
   assign w_en      = !out_valid | out_ready;
   assign in_ready  = w_en;
   assign w_xfer_in = in_valid & w_en;
   assign busy      = r_s1_valid | r_s2_valid | out_valid;

   assign w_ch_wrap = in_last | ({1'b0, r_ch} == (cfg_nch - (CH_W+1)'(1)));
   assign w_sum     = {in_acc[ACC_W-1], in_acc} + {r_bias[r_ch][ACC_W-1], r_bias[r_ch]};
   // Scale is unsigned: a zero MSB keeps it positive in the signed multiply
   assign w_prod    = $signed(r_s1_sum) * $signed({1'b0, r_s1_scale});

   // Parameter table is intentionally left out of reset
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         r_bias[cfg_addr]  <= cfg_bias;
         r_scale[cfg_addr] <= cfg_scale;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_scale <= '0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_prod  <= '0;
         r_s2_last  <= 1'b0;
         r_ch       <= '0;
      end else if (w_en) begin
         r_s1_valid <= w_xfer_in;
         if (w_xfer_in) begin
            r_s1_sum   <= w_sum;
            r_s1_scale <= r_scale[r_ch];
            r_s1_last  <= in_last;
            r_ch       <= w_ch_wrap ? '0 : r_ch + 1'b1;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_prod  <= w_prod;
         r_s2_last  <= r_s1_last;
      end
   end

   requant_round_sat #(
      .PROD_W (PROD_W)
   ) u_round_sat (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (r_s2_valid),
      .i_prod  (r_s2_prod),
      .i_last  (r_s2_last),
      .i_shift (cfg_shift),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_last  (out_last)
   );

endmodule

// File: tb/tb_acc_requant_stage.sv
// tb/tb_acc_requant_stage.sv - self-checking bench for acc_requant_stage
module tb_acc_requant_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_bias;
   logic [15:0] cfg_scale;
   logic [5:0]  cfg_shift;
   logic [4:0]  cfg_nch;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_acc;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   acc_requant_stage #(
      .ACC_W   (32),
      .SCALE_W (16),
      .NCH_MAX (16),
      .CH_W    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_bias  (cfg_bias),
      .cfg_scale (cfg_scale),
      .cfg_shift (cfg_shift),
      .cfg_nch   (cfg_nch),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] bias;
      logic [15:0] scale;
      logic [5:0]  shift;
      logic [31:0] acc;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[13];

   logic [31:0] s_acc[$];
   logic        s_last[$];
   logic [15:0] s_exp[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] addr, input logic [31:0] bias, input logic [15:0] scale);
      cfg_we    = 1'b1;
      cfg_addr  = addr;
      cfg_bias  = bias;
      cfg_scale = scale;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic push_one(input string name, input logic [31:0] acc, input logic [15:0] exp);
      int cyc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_acc    = acc;
      in_last   = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, cyc, 3);
      check({name, " data"}, out_data, exp);
      check({name, " last"}, out_last, 1'b1);
      tick();
   endtask

   task automatic run_stream(input string name, input bit rnd);
      int sent = 0;
      int rcvd = 0;
      int cyc  = 0;
      while (rcvd < s_exp.size() && cyc < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sent < s_acc.size()) begin
            in_valid = 1'b1;
            in_acc   = s_acc[sent];
            in_last  = s_last[sent];
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         #3;
         check({name, " in_ready"}, in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) begin
            check($sformatf("%s data[%0d]", name, rcvd), out_data, s_exp[rcvd]);
            check($sformatf("%s last[%0d]", name, rcvd), out_last, s_last[rcvd]);
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      check({name, " count"}, rcvd, s_exp.size());
      check({name, " drained"}, out_valid, 1'b0);
      s_acc.delete();
      s_last.delete();
      s_exp.delete();
   endtask

   initial begin
      vecs[0]  = '{"basic",    32'h0,        16'd256,  6'd8,  32'h00000300, 16'h0300};
      vecs[1]  = '{"rnd_p3",   32'h0,        16'd1,    6'd1,  32'd3,        16'h0002};
      vecs[2]  = '{"rnd_m3",   32'h0,        16'd1,    6'd1,  32'hFFFFFFFD, 16'hFFFF};
      vecs[3]  = '{"rnd_m4",   32'h0,        16'd1,    6'd1,  32'hFFFFFFFC, 16'hFFFE};
      vecs[4]  = '{"rnd_m1",   32'h0,        16'd1,    6'd1,  32'hFFFFFFFF, 16'h0000};
      vecs[5]  = '{"sat_pos",  32'h0,        16'd1,    6'd0,  32'h00010000, 16'h7FFF};
      vecs[6]  = '{"sat_neg",  32'h0,        16'd1,    6'd0,  32'hFFFF0000, 16'h8000};
      vecs[7]  = '{"max_ok",   32'h0,        16'd1,    6'd0,  32'h00007FFF, 16'h7FFF};
      vecs[8]  = '{"max_p1",   32'h0,        16'd1,    6'd0,  32'h00008000, 16'h7FFF};
      vecs[9]  = '{"min_ok",   32'h0,        16'd1,    6'd0,  32'hFFFF8000, 16'h8000};
      vecs[10] = '{"min_m1",   32'h0,        16'd1,    6'd0,  32'hFFFF7FFF, 16'h8000};
      vecs[11] = '{"neg_bias", 32'hFFFFFF9C, 16'd3,    6'd0,  32'd50,       16'hFF6A};
      vecs[12] = '{"wide47",   32'h7FFFFFFF, 16'hFFFF, 6'd47, 32'h7FFFFFFF, 16'h0002};

      rst       = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_bias  = '0;
      cfg_scale = '0;
      cfg_shift = '0;
      cfg_nch   = 5'd1;
      in_valid  = 1'b0;
      in_acc    = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("reset out_valid", out_valid, 1'b0);
      check("reset out_last", out_last, 1'b0);
      check("reset out_data", out_data, 16'h0);
      check("reset busy", busy, 1'b0);
      check("reset in_ready", in_ready, 1'b1);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 13; i++) begin
         cfg_nch   = 5'd1;
         cfg_shift = vecs[i].shift;
         cfg_write(4'd0, vecs[i].bias, vecs[i].scale);
         push_one(vecs[i].name, vecs[i].acc, vecs[i].exp);
      end

      // Channel walk over three channels, last on the final element
      cfg_nch   = 5'd3;
      cfg_shift = 6'd0;
      for (int c = 0; c < 3; c++) cfg_write(4'(c), 32'(c * 256), 16'd1);
      for (int i = 0; i < 7; i++) begin
         s_acc.push_back(32'h0);
         s_last.push_back(i == 6);
         s_exp.push_back(16'((i % 3) * 256));
      end
      run_stream("walk", 1'b0);

      // in_last every second element restarts the counter
      for (int i = 0; i < 6; i++) begin
         s_acc.push_back(32'h0);
         s_last.push_back(i % 2 == 1);
         s_exp.push_back((i % 2 == 1) ? 16'd256 : 16'd0);
      end
      run_stream("restart", 1'b0);

      // Backpressure with random out_ready
      cfg_nch = 5'd1;
      cfg_write(4'd0, 32'h0, 16'd1);
      for (int i = 0; i < 10; i++) begin
         s_acc.push_back(32'(i));
         s_last.push_back(i == 9);
         s_exp.push_back(16'(i));
      end
      run_stream("bp", 1'b1);

      // Reset with a full pipe, counter left at a nonzero channel
      cfg_nch = 5'd3;
      for (int c = 0; c < 3; c++) cfg_write(4'(c), 32'(c * 256), 16'd1);
      s_acc.push_back(32'h0);
      s_last.push_back(1'b0);
      s_exp.push_back(16'd0);
      run_stream("pre_rst", 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_acc    = 32'h0;
      in_last   = 1'b0;
      repeat (5) tick();
      check("full in_ready", in_ready, 1'b0);
      check("full out_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      rst      = 1'b0;
      tick();
      rst = 1'b1;
      check("post_rst out_valid", out_valid, 1'b0);
      check("post_rst busy", busy, 1'b0);
      push_one("post_rst ch0", 32'h0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
